bsg_link_upstream_out_param: RTL and testbench

Parametrised upstream link output stage. It accepts core words over a valid/ready handshake and serialises each word into beats across CHANNELS output channels of CH_W bits. A credit counter, replenished by token pulses from the downstream receiver, throttles transmission. It sits between the core-side fabric and the off-chip/IO link. It is the general-width, general-channel-count, token-decimated successor of the fixed 64-bit/2-channel sender.

---
 rtl/bsg_link_pkg.sv | 26 ++
 rtl/bsg_link_credit_counter.sv | 47 ++++
 rtl/bsg_link_upstream_out_param.sv | 88 ++++++++
 tb/tb_bsg_link_upstream_out_param.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/bsg_link_pkg.sv
// Shared types and sizing helpers for the upstream link output stage.
package bsg_link_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  // Number of link beats needed to carry one core word.
  function automatic int unsigned beats(input int unsigned core_w,
                                        input int unsigned channels,
                                        input int unsigned ch_w);
    return core_w / (channels * ch_w);
  endfunction

  // Width of a counter that can hold 0..credits inclusive.
  function automatic int unsigned credit_w(input int unsigned credits);
    return $clog2(credits) + 1;
  endfunction

  // Width of a beat index counter; at least one bit.
  function automatic int unsigned beat_cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bsg_link_credit_counter.sv
// Credit pool: one credit spent per accepted word, tokens return a batch of credits.
module bsg_link_credit_counter
  import bsg_link_pkg::*;
#(
  parameter int unsigned CREDITS        = 64,
  parameter int unsigned LG_TOKEN_RATIO = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          consume,
  input  logic                          token,
  output logic [credit_w(CREDITS)-1:0]  avail,
  output logic                          err
);

  localparam int unsigned CW = credit_w(CREDITS);
  localparam int unsigned R  = 32'(1) << LG_TOKEN_RATIO;

  logic [CW-1:0] avail_n;
  logic          err_n;
  int unsigned   outstanding;
  int unsigned   ret;

  // Next credit count: returns saturate at the outstanding count so the pool never exceeds CREDITS.
  always_comb begin
    outstanding = CREDITS - 32'(avail);
    ret         = 0;
    err_n       = err;
    if (token) begin
      if (outstanding == 0) err_n = 1'b1;
      ret = (outstanding < R) ? outstanding : R;
    end
    avail_n = CW'(32'(avail) - 32'(consume) + ret);
  end

  // Credit and sticky error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      avail <= CW'(CREDITS);
      err   <= 1'b0;
    end else begin
      avail <= avail_n;
      err   <= err_n;
    end
  end

endmodule

// File: rtl/bsg_link_upstream_out_param.sv
// Upstream link sender: serialises core words into CHANNELS*CH_W-bit beats under credit flow control.
module bsg_link_upstream_out_param
  import bsg_link_pkg::*;
#(
  parameter int unsigned CORE_W         = 64,
  parameter int unsigned CHANNELS       = 2,
  parameter int unsigned CH_W           = 8,
  parameter int unsigned CREDITS        = 64,
  parameter int unsigned LG_TOKEN_RATIO = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [CORE_W-1:0]             core_data_in,
  input  logic                          core_valid_in,
  output logic                          core_ready_out,
  input  logic                          io_token,
  output logic                          io_valid_out,
  output logic [CHANNELS*CH_W-1:0]      io_data_out,
  output logic [credit_w(CREDITS)-1:0]  credit_avail,
  output logic                          credit_err
);

  localparam int unsigned BW    = CHANNELS * CH_W;
  localparam int unsigned BEATS = beats(CORE_W, CHANNELS, CH_W);
  localparam int unsigned BCW   = beat_cnt_w(BEATS);

  state_e            state, state_n;
  logic [BCW-1:0]    b, b_n;
  logic [CORE_W-1:0] shreg, shreg_n;
  logic              last;
  logic              ready_c;
  logic              accept;

  bsg_link_credit_counter #(
    .CREDITS        (CREDITS),
    .LG_TOKEN_RATIO (LG_TOKEN_RATIO)
  ) u_credit (
    .clk     (clk),
    .rst     (rst),
    .consume (accept),
    .token   (io_token),
    .avail   (credit_avail),
    .err     (credit_err)
  );

  // Handshake and next-state: a new word may be taken on the final beat so words run back to back.
  always_comb begin
    state_n = state;
    b_n     = b;
    shreg_n = shreg;
    last    = (b == BCW'(BEATS - 1));
    ready_c = !rst && ((state == IDLE) || (state == SEND && last)) &&
              (credit_avail != '0);
    accept  = core_valid_in && ready_c;
    if (accept) begin
      state_n = SEND;
      b_n     = '0;
      shreg_n = core_data_in;
    end else if (state == SEND) begin
      if (last) begin
        state_n = IDLE;
      end else begin
        b_n     = b + BCW'(1);
        shreg_n = CORE_W'({{BW{1'b0}}, shreg} >> BW);
      end
    end
  end

  assign core_ready_out = ready_c;

  // State, beat counter, shift register and registered link outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      b            <= '0;
      shreg        <= '0;
      io_valid_out <= 1'b0;
      io_data_out  <= '0;
    end else begin
      state        <= state_n;
      b            <= b_n;
      shreg        <= shreg_n;
      io_valid_out <= (state == SEND);
      if (state == SEND) io_data_out <= shreg[BW-1:0];
    end
  end

endmodule

// File: tb/tb_bsg_link_upstream_out_param.sv
// Directed bench for the upstream link sender across several parameter sets.
module tb_bsg_link_upstream_out_param;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: defaults.
  logic [63:0] a_data;  logic a_valid, a_ready, a_token, a_iov, a_err;
  logic [15:0] a_iod;   logic [6:0] a_cred;
  // Instance B: CREDITS=4.
  logic [63:0] b_data;  logic b_valid, b_ready, b_token, b_iov, b_err;
  logic [15:0] b_iod;   logic [2:0] b_cred;
  // Instance C: CREDITS=8, LG_TOKEN_RATIO=2.
  logic [63:0] c_data;  logic c_valid, c_ready, c_token, c_iov, c_err;
  logic [15:0] c_iod;   logic [3:0] c_cred;
  // Instance D: one beat per word.
  logic [31:0] d_data;  logic d_valid, d_ready, d_token, d_iov, d_err;
  logic [31:0] d_iod;   logic [6:0] d_cred;

  bsg_link_upstream_out_param u_a (
    .clk(clk), .rst(rst), .core_data_in(a_data), .core_valid_in(a_valid),
    .core_ready_out(a_ready), .io_token(a_token), .io_valid_out(a_iov),
    .io_data_out(a_iod), .credit_avail(a_cred), .credit_err(a_err));

  bsg_link_upstream_out_param #(.CREDITS(4)) u_b (
    .clk(clk), .rst(rst), .core_data_in(b_data), .core_valid_in(b_valid),
    .core_ready_out(b_ready), .io_token(b_token), .io_valid_out(b_iov),
    .io_data_out(b_iod), .credit_avail(b_cred), .credit_err(b_err));

  bsg_link_upstream_out_param #(.CREDITS(8), .LG_TOKEN_RATIO(2)) u_c (
    .clk(clk), .rst(rst), .core_data_in(c_data), .core_valid_in(c_valid),
    .core_ready_out(c_ready), .io_token(c_token), .io_valid_out(c_iov),
    .io_data_out(c_iod), .credit_avail(c_cred), .credit_err(c_err));

  bsg_link_upstream_out_param #(.CORE_W(32), .CHANNELS(4), .CH_W(8)) u_d (
    .clk(clk), .rst(rst), .core_data_in(d_data), .core_valid_in(d_valid),
    .core_ready_out(d_ready), .io_token(d_token), .io_valid_out(d_iov),
    .io_data_out(d_iod), .credit_avail(d_cred), .credit_err(d_err));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int acc, nbeat, first, lastv, bad;
    rst = 1'b1;
    a_data = '0; a_valid = 0; a_token = 0;
    b_data = '0; b_valid = 0; b_token = 0;
    c_data = '0; c_valid = 0; c_token = 0;
    d_data = '0; d_valid = 0; d_token = 0;
    step(); step();

    // Reset state
    chk("rst_ready", a_ready, 0);
    chk("rst_iov", a_iov, 0);
    chk("rst_iod", a_iod, 0);
    chk("rst_cred", a_cred, 64);
    chk("rst_err", a_err, 0);
    rst = 1'b0;
    step();

    // Single word on default instance
    a_data = 64'h0807_0605_0403_0201; a_valid = 1;
    chk("a_ready_idle", a_ready, 1);
    step();
    a_valid = 0;
    chk("a_cred_63", a_cred, 63);
    chk("a_iov_t0", a_iov, 0);
    step(); chk("a_beat0_v", a_iov, 1); chk("a_beat0", a_iod, 16'h0201);
    step(); chk("a_beat1", a_iod, 16'h0403);
    step(); chk("a_beat2", a_iod, 16'h0605);
    step(); chk("a_beat3_v", a_iov, 1); chk("a_beat3", a_iod, 16'h0807);
    step(); chk("a_after_v", a_iov, 0); chk("a_hold", a_iod, 16'h0807);

    // Credit exhaustion with CREDITS=4
    b_data = 64'hFEDC_BA98_7654_3210; b_valid = 1;
    acc = 0; nbeat = 0; first = -1; lastv = -1;
    for (int i = 0; i < 24; i++) begin
      if (b_valid && b_ready) acc++;
      step();
      if (b_iov) begin
        nbeat++;
        if (first < 0) first = i;
        lastv = i;
      end
    end
    chk("b_accepts", 64'(acc), 4);
    chk("b_beats", 64'(nbeat), 16);
    chk("b_contig", 64'(lastv - first + 1), 16);
    chk("b_ready_0", b_ready, 0);
    chk("b_cred_0", b_cred, 0);
    b_token = 1;
    step();
    b_token = 0;
    chk("b_cred_tok", b_cred, 1);
    chk("b_ready_tok", b_ready, 1);
    step();
    chk("b_tok_t1_v", b_iov, 0);
    step();
    chk("b_tok_t2_v", b_iov, 1);
    chk("b_tok_t2_d", b_iod, 16'h3210);
    b_valid = 0;
    for (int i = 0; i < 4; i++) step();
    b_token = 1;
    step();
    chk("b_cred_1", b_cred, 1);
    // Accept and token on the same edge with one credit left
    b_valid = 1; b_token = 1;
    chk("b_ready_same", b_ready, 1);
    step();
    b_valid = 0; b_token = 0;
    chk("b_same_cred", b_cred, 1);
    chk("b_same_err", b_err, 0);

    // Token ratio 4, CREDITS=8
    c_data = 64'h1122_3344_5566_7788; c_valid = 1;
    acc = 0;
    for (int n = 0; n < 60 && acc < 6; n++) begin
      if (c_valid && c_ready) acc++;
      step();
      if (acc == 6) c_valid = 0;
    end
    c_valid = 0;
    chk("c_accepts", 64'(acc), 6);
    chk("c_cred_2", c_cred, 2);
    c_token = 1; step(); c_token = 0;
    chk("c_cred_6", c_cred, 6);
    chk("c_err_a", c_err, 0);
    c_token = 1; step(); c_token = 0;
    chk("c_cred_8", c_cred, 8);
    chk("c_err_b", c_err, 0);
    c_token = 1; step(); c_token = 0;
    chk("c_cred_8b", c_cred, 8);
    chk("c_err_c", c_err, 1);

    // One beat per word: a word every cycle
    d_valid = 1;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      d_data = 32'h1000_0000 + 32'(i);
      if (!d_ready) bad++;
      step();
      if (i >= 1) begin
        if (!d_iov) bad++;
        if (d_iod != 32'h1000_0000 + 32'(i - 1)) bad++;
      end
    end
    d_valid = 0;
    chk("d_stream", 64'(bad), 0);
    chk("d_cred", d_cred, 56);

    // Reset during beat 2 of a word
    a_data = 64'hAAAA_BBBB_CCCC_DDDD; a_valid = 1;
    step();
    a_valid = 0;
    step(); step(); step();
    chk("a_mid_beat2", a_iod, 16'hBBBB);
    rst = 1;
    step();
    chk("a_rst_iov", a_iov, 0);
    chk("a_rst_ready", a_ready, 0);
    rst = 0;
    chk("a_rst_cred", a_cred, 64);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (a_iov) bad++;
    end
    chk("a_no_residual", 64'(bad), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
